// File: rtl/reg_bank_dbuf_if.sv
// Write/commit bus of the double-buffered register bank. The game logic drives
// it as master; the register bank is the slave.
interface reg_bank_dbuf_if #(
  parameter int WIDTH    = 20,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic                      Load;
  logic [SEL_W-1:0]          Sel;
  logic [WIDTH-1:0]          D;
  logic                      Commit;
  logic                      Clear;
  logic [CHANNELS*WIDTH-1:0] Data_Out;
  logic [CHANNELS-1:0]       Dirty;
  logic                      Pending;
  logic                      Committed;

  modport master (
    output Load, Sel, D, Commit, Clear,
    input  Data_Out, Dirty, Pending, Committed
  );

  modport slave (
    input  Load, Sel, D, Commit, Clear,
    output Data_Out, Dirty, Pending, Committed
  );
endinterface

// File: rtl/reg_bank_dbuf.sv
// Multi-channel register bank: writes are staged per channel and become active
// together on a frame-boundary Commit, or land directly when SHADOW=0.
module reg_bank_dbuf #(
  parameter int               WIDTH     = 20,
  parameter int               CHANNELS  = 4,
  parameter bit               SHADOW    = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic           Clk,
  input  logic           Reset_n,
  reg_bank_dbuf_if.slave bus
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [WIDTH-1:0] act_q [CHANNELS];
  logic [WIDTH-1:0] act_d [CHANNELS];
  logic             load_ok;

  // Out-of-range selects (non-power-of-two CHANNELS) are silently dropped.
  assign load_ok = bus.Load && (32'(bus.Sel) < CHANNELS);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_out
    assign bus.Data_Out[g*WIDTH +: WIDTH] = act_q[g];
  end

  if (SHADOW) begin : g_shadow
    logic [WIDTH-1:0]    stg_q [CHANNELS];
    logic [WIDTH-1:0]    stg_d [CHANNELS];
    logic [CHANNELS-1:0] dirty_q;
    logic [CHANNELS-1:0] dirty_d;
    logic                committed_q;
    logic                committed_d;

    // Clear beats Commit beats Load; a same-channel Commit+Load transfers the
    // old staged value while the new one stays staged and dirty.
    always_comb begin
      act_d       = act_q;
      stg_d       = stg_q;
      dirty_d     = dirty_q;
      committed_d = 1'b0;
      if (bus.Clear) begin
        stg_d   = act_q;
        dirty_d = '0;
      end else begin
        if (bus.Commit) begin
          committed_d = |dirty_q;
          for (int i = 0; i < CHANNELS; i++) begin
            if (dirty_q[i]) begin
              act_d[i]   = stg_q[i];
              dirty_d[i] = 1'b0;
            end
          end
        end
        if (load_ok) begin
          for (int i = 0; i < CHANNELS; i++) begin
            if (bus.Sel == SEL_W'(i)) begin
              stg_d[i]   = bus.D;
              dirty_d[i] = 1'b1;
            end
          end
        end
      end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        for (int i = 0; i < CHANNELS; i++) begin
          act_q[i] <= RESET_VAL;
          stg_q[i] <= RESET_VAL;
        end
        dirty_q     <= '0;
        committed_q <= 1'b0;
      end else begin
        act_q       <= act_d;
        stg_q       <= stg_d;
        dirty_q     <= dirty_d;
        committed_q <= committed_d;
      end
    end

    assign bus.Dirty     = dirty_q;
    assign bus.Pending   = |dirty_q;
    assign bus.Committed = committed_q;
  end else begin : g_direct
    logic unused_ctrl;

    always_comb begin
      act_d = act_q;
      for (int i = 0; i < CHANNELS; i++) begin
        if (load_ok && (bus.Sel == SEL_W'(i))) act_d[i] = bus.D;
      end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        for (int i = 0; i < CHANNELS; i++) act_q[i] <= RESET_VAL;
      end else begin
        act_q <= act_d;
      end
    end

    assign unused_ctrl   = bus.Commit ^ bus.Clear;
    assign bus.Dirty     = '0;
    assign bus.Pending   = 1'b0;
    assign bus.Committed = 1'b0;
  end
endmodule

// File: tb/tb_reg_bank_dbuf.sv
// Bench for reg_bank_dbuf: a shadowed 4-channel instance and a direct 3-channel
// instance, driven by directed tables/sequences and random traffic vs a model.
module tb_reg_bank_dbuf;
  localparam logic [19:0] R = 20'h00010;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  reg_bank_dbuf_if #(.WIDTH(20), .CHANNELS(4)) bus_a ();
  reg_bank_dbuf_if #(.WIDTH(20), .CHANNELS(3)) bus_b ();

  reg_bank_dbuf #(.WIDTH(20), .CHANNELS(4), .SHADOW(1'b1), .RESET_VAL(R)) dut_a (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus_a));
  reg_bank_dbuf #(.WIDTH(20), .CHANNELS(3), .SHADOW(1'b0), .RESET_VAL(20'h0)) dut_b (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus_b));

  int vectors = 0;
  int miscompares = 0;

  // Reference: active value per channel plus an optional pending value.
  logic [19:0] ma_act [4];
  logic [19:0] ma_pval [4];
  logic [3:0]  ma_pv;
  logic        ma_comm;
  logic [19:0] mb_act [3];

  typedef struct {
    logic        load;
    logic [1:0]  sel;
    logic [19:0] d;
    logic        commit;
    logic        clear;
    logic [79:0] exp_out;
    logic [3:0]  exp_dirty;
    logic        exp_comm;
  } vec_t;
  vec_t tbl [17];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      ma_act[i] = R;
      ma_pval[i] = '0;
    end
    ma_pv = '0;
    ma_comm = 1'b0;
    for (int i = 0; i < 3; i++) mb_act[i] = '0;
  endtask

  function automatic logic [79:0] ma_out();
    return {ma_act[3], ma_act[2], ma_act[1], ma_act[0]};
  endfunction

  function automatic logic [59:0] mb_out();
    return {mb_act[2], mb_act[1], mb_act[0]};
  endfunction

  task automatic step_a(input logic ld, input logic [1:0] s, input logic [19:0] dd,
                        input logic cm, input logic cl);
    bus_a.Load = ld; bus_a.Sel = s; bus_a.D = dd; bus_a.Commit = cm; bus_a.Clear = cl;
    @(posedge Clk);
    #1;
    ma_comm = 1'b0;
    if (cl) begin
      ma_pv = '0;
    end else begin
      if (cm) begin
        for (int i = 0; i < 4; i++) begin
          if (ma_pv[i]) begin
            ma_act[i] = ma_pval[i];
            ma_pv[i] = 1'b0;
            ma_comm = 1'b1;
          end
        end
      end
      if (ld) begin
        ma_pval[s] = dd;
        ma_pv[s] = 1'b1;
      end
    end
    bus_a.Load = 1'b0; bus_a.Commit = 1'b0; bus_a.Clear = 1'b0;
  endtask

  task automatic step_b(input logic ld, input logic [1:0] s, input logic [19:0] dd,
                        input logic cm, input logic cl);
    bus_b.Load = ld; bus_b.Sel = s; bus_b.D = dd; bus_b.Commit = cm; bus_b.Clear = cl;
    @(posedge Clk);
    #1;
    if (ld && s < 2'd3) mb_act[s] = dd;
    bus_b.Load = 1'b0; bus_b.Commit = 1'b0; bus_b.Clear = 1'b0;
  endtask

  task automatic chk_a_model(input string tag);
    chk({tag, "_data"}, 128'(bus_a.Data_Out), 128'(ma_out()));
    chk({tag, "_dirty"}, 128'(bus_a.Dirty), 128'(ma_pv));
    chk({tag, "_pending"}, 128'(bus_a.Pending), 128'(|ma_pv));
    chk({tag, "_committed"}, 128'(bus_a.Committed), 128'(ma_comm));
  endtask

  initial begin
    bus_a.Load = 0; bus_a.Sel = 0; bus_a.D = 0; bus_a.Commit = 0; bus_a.Clear = 0;
    bus_b.Load = 0; bus_b.Sel = 0; bus_b.D = 0; bus_b.Commit = 0; bus_b.Clear = 0;
    model_reset();

    // Row order: load sel d commit clear | Data_Out{ch3..ch0} Dirty Committed
    tbl[0]  = '{1'b0, 2'd0, 20'h0,     1'b1, 1'b0, {R, 20'hABCDE, R, R}, 4'h0, 1'b1};
    tbl[1]  = '{1'b0, 2'd0, 20'h0,     1'b0, 1'b0, {R, 20'hABCDE, R, R}, 4'h0, 1'b0};
    tbl[2]  = '{1'b1, 2'd1, 20'h00005, 1'b0, 1'b0, {R, 20'hABCDE, R, R}, 4'h2, 1'b0};
    tbl[3]  = '{1'b1, 2'd1, 20'h00007, 1'b0, 1'b0, {R, 20'hABCDE, R, R}, 4'h2, 1'b0};
    tbl[4]  = '{1'b0, 2'd0, 20'h0,     1'b1, 1'b0, {R, 20'hABCDE, 20'h00007, R}, 4'h0, 1'b1};
    tbl[5]  = '{1'b0, 2'd0, 20'h0,     1'b1, 1'b0, {R, 20'hABCDE, 20'h00007, R}, 4'h0, 1'b0};
    tbl[6]  = '{1'b1, 2'd0, 20'h11111, 1'b0, 1'b0, {R, 20'hABCDE, 20'h00007, R}, 4'h1, 1'b0};
    tbl[7]  = '{1'b1, 2'd0, 20'h22222, 1'b1, 1'b0, {R, 20'hABCDE, 20'h00007, 20'h11111}, 4'h1, 1'b1};
    tbl[8]  = '{1'b0, 2'd0, 20'h0,     1'b1, 1'b0, {R, 20'hABCDE, 20'h00007, 20'h22222}, 4'h0, 1'b1};
    tbl[9]  = '{1'b1, 2'd3, 20'h00009, 1'b0, 1'b0, {R, 20'hABCDE, 20'h00007, 20'h22222}, 4'h8, 1'b0};
    tbl[10] = '{1'b0, 2'd0, 20'h0,     1'b1, 1'b1, {R, 20'hABCDE, 20'h00007, 20'h22222}, 4'h0, 1'b0};
    tbl[11] = '{1'b0, 2'd0, 20'h0,     1'b1, 1'b0, {R, 20'hABCDE, 20'h00007, 20'h22222}, 4'h0, 1'b0};
    tbl[12] = '{1'b1, 2'd3, 20'h00001, 1'b0, 1'b1, {R, 20'hABCDE, 20'h00007, 20'h22222}, 4'h0, 1'b0};
    tbl[13] = '{1'b1, 2'd2, 20'h00033, 1'b1, 1'b0, {R, 20'hABCDE, 20'h00007, 20'h22222}, 4'h4, 1'b0};
    tbl[14] = '{1'b1, 2'd0, 20'h00044, 1'b1, 1'b0, {R, 20'h00033, 20'h00007, 20'h22222}, 4'h1, 1'b1};
    tbl[15] = '{1'b0, 2'd0, 20'h0,     1'b0, 1'b1, {R, 20'h00033, 20'h00007, 20'h22222}, 4'h0, 1'b0};
    tbl[16] = '{1'b0, 2'd0, 20'h0,     1'b1, 1'b0, {R, 20'h00033, 20'h00007, 20'h22222}, 4'h0, 1'b0};

    // Held in reset across two edges, checked mid-cycle.
    #22;
    chk("rst_data_a", 128'(bus_a.Data_Out), 128'({R, R, R, R}));
    chk("rst_dirty_a", 128'(bus_a.Dirty), 128'(0));
    chk("rst_pending_a", 128'(bus_a.Pending), 128'(0));
    chk("rst_committed_a", 128'(bus_a.Committed), 128'(0));
    chk("rst_data_b", 128'(bus_b.Data_Out), 128'(0));
    Reset_n = 1'b1;

    // Staged write stays invisible while uncommitted.
    step_a(1'b1, 2'd2, 20'hABCDE, 1'b0, 1'b0);
    chk("stage_dirty", 128'(bus_a.Dirty), 128'(4'b0100));
    chk("stage_pending", 128'(bus_a.Pending), 128'(1));
    chk("stage_data", 128'(bus_a.Data_Out), 128'({R, R, R, R}));
    for (int c = 0; c < 10; c++) begin
      step_a(1'b0, 2'd0, 20'h0, 1'b0, 1'b0);
      chk("stage_hold_ch2", 128'(bus_a.Data_Out[59:40]), 128'(R));
      chk("stage_hold_pending", 128'(bus_a.Pending), 128'(1));
    end

    for (int v = 0; v < 17; v++) begin
      step_a(tbl[v].load, tbl[v].sel, tbl[v].d, tbl[v].commit, tbl[v].clear);
      chk($sformatf("tbl%0d_data", v), 128'(bus_a.Data_Out), 128'(tbl[v].exp_out));
      chk($sformatf("tbl%0d_dirty", v), 128'(bus_a.Dirty), 128'(tbl[v].exp_dirty));
      chk($sformatf("tbl%0d_pending", v), 128'(bus_a.Pending), 128'(|tbl[v].exp_dirty));
      chk($sformatf("tbl%0d_committed", v), 128'(bus_a.Committed), 128'(tbl[v].exp_comm));
    end

    for (int c = 0; c < 300; c++) begin
      step_a($urandom_range(1, 0) == 1, 2'($urandom_range(3, 0)), 20'($urandom),
             $urandom_range(4, 0) == 0, $urandom_range(19, 0) == 0);
      chk_a_model("rnd_a");
    end

    // Asynchronous reset mid-cycle with a write pending.
    step_a(1'b1, 2'd0, 20'hFFFFF, 1'b0, 1'b0);
    step_a(1'b1, 2'd1, 20'h12345, 1'b1, 1'b0);
    chk("pre_rst_committed", 128'(bus_a.Committed), 128'(1));
    chk("pre_rst_dirty", 128'(bus_a.Dirty), 128'(4'b0010));
    #3;
    Reset_n = 1'b0;
    #1;
    chk("async_rst_data_a", 128'(bus_a.Data_Out), 128'({R, R, R, R}));
    chk("async_rst_dirty_a", 128'(bus_a.Dirty), 128'(0));
    chk("async_rst_committed_a", 128'(bus_a.Committed), 128'(0));
    @(posedge Clk);
    #1;
    chk("rst_hold_data_a", 128'(bus_a.Data_Out), 128'({R, R, R, R}));
    chk("rst_hold_data_b", 128'(bus_b.Data_Out), 128'(0));
    #3;
    Reset_n = 1'b1;
    model_reset();

    // Direct mode: immediate write, out-of-range select and control ignored.
    step_b(1'b1, 2'd1, 20'h00042, 1'b0, 1'b0);
    chk("direct_load", 128'(bus_b.Data_Out), 128'({20'h0, 20'h00042, 20'h0}));
    step_b(1'b1, 2'd3, 20'h00099, 1'b0, 1'b0);
    chk("direct_sel_oob", 128'(bus_b.Data_Out), 128'({20'h0, 20'h00042, 20'h0}));
    step_b(1'b0, 2'd0, 20'h0, 1'b1, 1'b1);
    chk("direct_ctrl_data", 128'(bus_b.Data_Out), 128'({20'h0, 20'h00042, 20'h0}));
    chk("direct_dirty", 128'(bus_b.Dirty), 128'(0));
    chk("direct_committed", 128'(bus_b.Committed), 128'(0));
    step_b(1'b1, 2'd0, 20'h00007, 1'b1, 1'b0);
    chk("direct_load_commit", 128'(bus_b.Data_Out), 128'({20'h0, 20'h00042, 20'h00007}));
    chk("direct_pending", 128'(bus_b.Pending), 128'(0));

    for (int c = 0; c < 200; c++) begin
      step_b($urandom_range(1, 0) == 1, 2'($urandom_range(3, 0)), 20'($urandom),
             $urandom_range(3, 0) == 0, $urandom_range(3, 0) == 0);
      chk("rnd_b_data", 128'(bus_b.Data_Out), 128'(mb_out()));
      chk("rnd_b_dirty", 128'(bus_b.Dirty), 128'(0));
      chk("rnd_b_committed", 128'(bus_b.Committed), 128'(0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
